// File: rtl/vector_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : vector_mul_pipe
//  Description : Two-stage, back-pressurable LANES x W unsigned vector
//                multiplier returning element-wise products or a dot product.
//                Optional lane clamping when SATURATE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_mul_pipe #(
   parameter  int LANES = 4,
   parameter  int W     = 8,
   localparam int ACCW  = 2*W + $clog2(LANES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               mode,
   input  logic [LANES*W-1:0] a,
   input  logic [LANES*W-1:0] b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES*W-1:0] c,
   output logic [ACCW-1:0]    dot,
   output logic               out_mode,
   output logic               sat,
   output logic [15:0]        ops_done
);

   localparam int PW = 2*W;
`ifdef SATURATE_EN
   localparam logic [PW-1:0] C_LANE_MAX = {{W{1'b0}}, {W{1'b1}}};
`endif

   logic [LANES*PW-1:0] w_prod;
   logic [LANES*PW-1:0] r_s1_p;
   logic                r_s1_full;
   logic                r_s1_mode;

   logic [LANES*W-1:0]  w_c;
   logic [ACCW-1:0]     w_dot;
   logic                w_sat;
   logic [PW-1:0]       w_lane;

   logic                w_s2_load;
   logic                w_in_fire;
   logic                w_out_fire;

   logic                r_out_valid;
   logic [LANES*W-1:0]  r_c;
   logic [ACCW-1:0]     r_dot;
   logic                r_out_mode;
   logic                r_sat;
   logic [15:0]         r_ops_done;

   // S2 may refill whenever its current result leaves (or it is empty).
   assign w_s2_load  = r_s1_full && (!r_out_valid || out_ready);
   assign in_ready   = !r_s1_full || w_s2_load;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = r_out_valid && out_ready;

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         assign w_prod[i*PW +: PW] = PW'(a[i*W +: W]) * PW'(b[i*W +: W]);
      end
   endgenerate

   always_comb begin
      w_c    = '0;
      w_dot  = '0;
      w_sat  = 1'b0;
      w_lane = '0;
      for (int i = 0; i < LANES; i++) begin
         w_lane = r_s1_p[i*PW +: PW];
         if (r_s1_mode) begin
            w_dot = w_dot + ACCW'(w_lane);
         end else begin
`ifdef SATURATE_EN
            if (w_lane > C_LANE_MAX) begin
               w_c[i*W +: W] = '1;
               w_sat         = 1'b1;
            end else begin
               w_c[i*W +: W] = w_lane[W-1:0];
            end
`else
            w_c[i*W +: W] = w_lane[W-1:0];
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_full <= 1'b0;
         r_s1_mode <= 1'b0;
         r_s1_p    <= '0;
      end else if (w_in_fire) begin
         r_s1_full <= 1'b1;
         r_s1_mode <= mode;
         r_s1_p    <= w_prod;
      end else if (w_s2_load) begin
         r_s1_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_c         <= '0;
         r_dot       <= '0;
         r_out_mode  <= 1'b0;
         r_sat       <= 1'b0;
      end else if (w_s2_load) begin
         r_out_valid <= 1'b1;
         r_c         <= w_c;
         r_dot       <= w_dot;
         r_out_mode  <= r_s1_mode;
         r_sat       <= w_sat;
      end else if (w_out_fire) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ops_done <= 16'd0;
      end else if (w_out_fire) begin
         r_ops_done <= r_ops_done + 16'd1;
      end
   end

   assign out_valid = r_out_valid;
   assign c         = r_c;
   assign dot       = r_dot;
   assign out_mode  = r_out_mode;
   assign sat       = r_sat;
   assign ops_done  = r_ops_done;

endmodule
`default_nettype wire
